// File: rtl/tt_um_freq_meter_pkg.sv
// Shared constants for the gated frequency meter: FSM encoding, gate
// length exponents, status-bit positions and the gate-length helper.
`timescale 1ns/1ps
package tt_um_freq_meter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GATE = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    // Gate length is 2^(GATE_EXP_BASE + GATE_EXP_STEP*gate_sel) cycles.
    localparam int GATE_EXP_BASE = 8;
    localparam int GATE_EXP_STEP = 2;
    // Wide enough to hold length-1 of the longest gate (16384 cycles).
    localparam int GATE_CNT_W    = 14;

    // Bit positions of the status flags on uio_out.
    localparam int UIO_BUSY = 0;
    localparam int UIO_DONE = 1;
    localparam int UIO_OVF  = 2;

    localparam logic [7:0] UIO_OE_MASK = 8'b0000_0111;

    // Last gate-counter value of a window selected by sel (length - 1).
    function automatic logic [GATE_CNT_W-1:0] gate_last(input logic [1:0] sel);
        logic [GATE_CNT_W:0] len;
        len = (GATE_CNT_W+1)'(1) << (GATE_EXP_BASE + GATE_EXP_STEP * int'(sel));
        return GATE_CNT_W'(len - (GATE_CNT_W+1)'(1));
    endfunction

endpackage

// File: rtl/sync_edge.sv
// Two-flop synchronizer with a third delay flop; rise pulses for one
// cycle when the synchronized input goes from 0 to 1.
`timescale 1ns/1ps
module sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q,
    output logic rise
);

    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Synchronizer chain plus the edge-detect delay stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign q    = s2_q;
    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/tt_um_freq_meter.sv
// Gated frequency meter: counts synchronized rising edges of ui_in[0]
// during a programmable window of system-clock cycles and holds the count.
`timescale 1ns/1ps
module tt_um_freq_meter
    import tt_um_freq_meter_pkg::*;
#(
    parameter int CNT_W = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam logic [CNT_W-1:0] EDGE_MAX = '1;

    state_e                  state_q, state_d;
    logic [GATE_CNT_W-1:0]   gate_cnt_q, gate_cnt_d;
    logic [1:0]              gate_sel_q, gate_sel_d;
    logic [CNT_W-1:0]        edge_cnt_q, edge_cnt_d;
    logic [CNT_W-1:0]        result_q, result_d;
    logic                    ovf_q, ovf_d;

    logic sig_sync, sig_rise;
    logic start_sync, start_rise;
    logic busy, done;
    logic [7:0] hi_byte;

    sync_edge u_sig_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[0]),
        .q     (sig_sync),
        .rise  (sig_rise)
    );

    sync_edge u_start_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[1]),
        .q     (start_sync),
        .rise  (start_rise)
    );

    // State register and datapath registers; reset aborts any measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            gate_cnt_q <= '0;
            gate_sel_q <= '0;
            edge_cnt_q <= '0;
            result_q   <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            gate_cnt_q <= gate_cnt_d;
            gate_sel_q <= gate_sel_d;
            edge_cnt_q <= edge_cnt_d;
            result_q   <= result_d;
            ovf_q      <= ovf_d;
        end
    end

    // Next-state logic: arm on start from IDLE/HOLD, count during GATE,
    // capture the count (including a last-cycle edge) into result on exit.
    always_comb begin
        state_d    = state_q;
        gate_cnt_d = gate_cnt_q;
        gate_sel_d = gate_sel_q;
        edge_cnt_d = edge_cnt_q;
        result_d   = result_q;
        ovf_d      = ovf_q;
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if (start_rise) begin
                    state_d    = ST_GATE;
                    gate_cnt_d = '0;
                    gate_sel_d = ui_in[3:2];
                    edge_cnt_d = '0;
                    ovf_d      = 1'b0;
                end
            end
            ST_GATE: begin
                gate_cnt_d = gate_cnt_q + GATE_CNT_W'(1);
                if (sig_rise) begin
                    if (edge_cnt_q == EDGE_MAX) begin
                        ovf_d = 1'b1;
                    end else begin
                        edge_cnt_d = edge_cnt_q + CNT_W'(1);
                    end
                end
                if (gate_cnt_q == gate_last(gate_sel_q)) begin
                    state_d  = ST_HOLD;
                    result_d = edge_cnt_d;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy = (state_q == ST_GATE);
    assign done = (state_q == ST_HOLD);

    // Output formatting: byte_sel picks low result byte or {ovf, pad, high bits}.
    always_comb begin
        hi_byte                = '0;
        hi_byte[7]             = ovf_q;
        hi_byte[CNT_W-9:0]     = result_q[CNT_W-1:8];
        uo_out                 = ui_in[4] ? hi_byte : result_q[7:0];
        uio_out                = '0;
        uio_out[UIO_BUSY]      = busy;
        uio_out[UIO_DONE]      = done;
        uio_out[UIO_OVF]       = ovf_q;
    end

    assign uio_oe = UIO_OE_MASK;

    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in, ui_in[7:5], sig_sync, start_sync};

endmodule
